// File: rtl/rs_alu_scheduler_if.sv
// Dispatch, CDB snoop and ALU-issue signals of the ALU reservation station.
// The master side belongs to the dispatcher/CDB/ALU environment, the slave side to the station.
`ifndef OPENUM_NOP
`define OPENUM_NOP 6'd0
`endif
`ifndef ZERO_ROB
`define ZERO_ROB 4'd0
`endif

interface rs_alu_scheduler_if #(
   parameter int TAG_W  = 4,
   parameter int DATA_W = 32,
   parameter int OP_W   = 6
);
   logic              in_valid;
   logic [OP_W-1:0]   in_op;
   logic [TAG_W-1:0]  in_q1;
   logic [TAG_W-1:0]  in_q2;
   logic [DATA_W-1:0] in_v1;
   logic [DATA_W-1:0] in_v2;
   logic [DATA_W-1:0] in_imm;
   logic [DATA_W-1:0] in_pc;
   logic [TAG_W-1:0]  in_rob_tag;
   logic              out_full;
   logic [TAG_W-1:0]  alu_cdb_tag;
   logic [DATA_W-1:0] alu_cdb_value;
   logic [TAG_W-1:0]  lsb_cdb_tag;
   logic [DATA_W-1:0] lsb_cdb_value;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_value1;
   logic [DATA_W-1:0] alu_value2;
   logic [DATA_W-1:0] alu_imm;
   logic [DATA_W-1:0] alu_pc;
   logic [TAG_W-1:0]  alu_rob_tag;

   modport master (
      output in_valid, in_op, in_q1, in_q2, in_v1, in_v2, in_imm, in_pc, in_rob_tag,
      output alu_cdb_tag, alu_cdb_value, lsb_cdb_tag, lsb_cdb_value,
      input  out_full, alu_op, alu_value1, alu_value2, alu_imm, alu_pc, alu_rob_tag
   );

   modport slave (
      input  in_valid, in_op, in_q1, in_q2, in_v1, in_v2, in_imm, in_pc, in_rob_tag,
      input  alu_cdb_tag, alu_cdb_value, lsb_cdb_tag, lsb_cdb_value,
      output out_full, alu_op, alu_value1, alu_value2, alu_imm, alu_pc, alu_rob_tag
   );
endinterface

// File: rtl/rs_alu_scheduler.sv
// ALU reservation station: buffers dispatched ops, snoops both CDBs for operands
// and issues the lowest-index ready entry into registered ALU operands each cycle.
module rs_alu_scheduler #(
   parameter int RS_SIZE = 16,
   parameter int TAG_W   = 4,
   parameter int DATA_W  = 32,
   parameter int OP_W    = 6
) (
   input logic               clk,
   input logic               rst,
   input logic               rdy,
   input logic               clr,
   rs_alu_scheduler_if.slave bus
);
   localparam int IDX_W = $clog2(RS_SIZE);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [OP_W-1:0]  OP_NOP   = OP_W'(`OPENUM_NOP);
   localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(`ZERO_ROB);

   typedef struct packed {
      logic [TAG_W-1:0]  q;
      logic [DATA_W-1:0] v;
   } operand_t;

   typedef struct packed {
      logic              busy;
      logic [OP_W-1:0]   op;
      operand_t          s1;
      operand_t          s2;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
      logic [TAG_W-1:0]  rob_tag;
   } entry_t;

   // ALU bus is checked first so it wins when both tags match.
   function automatic operand_t resolve(input operand_t src,
                                        input logic [TAG_W-1:0] a_tag, input logic [DATA_W-1:0] a_val,
                                        input logic [TAG_W-1:0] l_tag, input logic [DATA_W-1:0] l_val);
      operand_t res;
      res = src;
      if (src.q != TAG_NONE && src.q == a_tag) begin
         res = operand_t'{TAG_NONE, a_val};
      end else if (src.q != TAG_NONE && src.q == l_tag) begin
         res = operand_t'{TAG_NONE, l_val};
      end else begin
         res = src;
      end
      return res;
   endfunction

   entry_t            entry_q [RS_SIZE];
   entry_t            entry_d [RS_SIZE];
   logic [OP_W-1:0]   alu_op_q, alu_op_d;
   logic [DATA_W-1:0] alu_value1_q, alu_value1_d;
   logic [DATA_W-1:0] alu_value2_q, alu_value2_d;
   logic [DATA_W-1:0] alu_imm_q, alu_imm_d;
   logic [DATA_W-1:0] alu_pc_q, alu_pc_d;
   logic [TAG_W-1:0]  alu_rob_tag_q, alu_rob_tag_d;

   logic              issue_found_s;
   logic [IDX_W-1:0]  issue_idx_s;
   logic              free_found_s;
   logic [IDX_W-1:0]  free_idx_s;
   logic [CNT_W-1:0]  busy_cnt_s;
   logic              dispatch_en_s;
   entry_t            new_entry_s;

   // Select issue/free slots, snoop CDBs, then apply issue, dispatch or flush.
   always_comb begin
      entry_d       = entry_q;
      alu_op_d      = OP_NOP;
      alu_rob_tag_d = TAG_NONE;
      alu_value1_d  = alu_value1_q;
      alu_value2_d  = alu_value2_q;
      alu_imm_d     = alu_imm_q;
      alu_pc_d      = alu_pc_q;
      issue_found_s = 1'b0;
      issue_idx_s   = '0;
      free_found_s  = 1'b0;
      free_idx_s    = '0;
      busy_cnt_s    = '0;

      // Descending scan so the lowest index is the one that sticks.
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         logic ready_v;
         ready_v       = entry_q[i].busy && entry_q[i].s1.q == TAG_NONE && entry_q[i].s2.q == TAG_NONE;
         issue_idx_s   = ready_v ? IDX_W'(i) : issue_idx_s;
         issue_found_s = issue_found_s | ready_v;
         free_idx_s    = !entry_q[i].busy ? IDX_W'(i) : free_idx_s;
         free_found_s  = free_found_s | !entry_q[i].busy;
         busy_cnt_s    = busy_cnt_s + CNT_W'(entry_q[i].busy);
      end

      for (int i = 0; i < RS_SIZE; i++) begin
         entry_d[i].s1 = resolve(entry_q[i].s1, bus.alu_cdb_tag, bus.alu_cdb_value,
                                 bus.lsb_cdb_tag, bus.lsb_cdb_value);
         entry_d[i].s2 = resolve(entry_q[i].s2, bus.alu_cdb_tag, bus.alu_cdb_value,
                                 bus.lsb_cdb_tag, bus.lsb_cdb_value);
      end

      new_entry_s = '{busy: 1'b1, op: bus.in_op,
                      s1: resolve(operand_t'{bus.in_q1, bus.in_v1}, bus.alu_cdb_tag, bus.alu_cdb_value,
                                  bus.lsb_cdb_tag, bus.lsb_cdb_value),
                      s2: resolve(operand_t'{bus.in_q2, bus.in_v2}, bus.alu_cdb_tag, bus.alu_cdb_value,
                                  bus.lsb_cdb_tag, bus.lsb_cdb_value),
                      imm: bus.in_imm, pc: bus.in_pc, rob_tag: bus.in_rob_tag};
      dispatch_en_s = bus.in_valid && free_found_s && !clr;

      if (clr) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            entry_d[i].busy = 1'b0;
         end
      end else if (issue_found_s) begin
         alu_op_d                 = entry_q[issue_idx_s].op;
         alu_value1_d             = entry_q[issue_idx_s].s1.v;
         alu_value2_d             = entry_q[issue_idx_s].s2.v;
         alu_imm_d                = entry_q[issue_idx_s].imm;
         alu_pc_d                 = entry_q[issue_idx_s].pc;
         alu_rob_tag_d            = entry_q[issue_idx_s].rob_tag;
         entry_d[issue_idx_s].busy = 1'b0;
      end else begin
         alu_op_d      = OP_NOP;
         alu_rob_tag_d = TAG_NONE;
      end

      // Free slot comes from registered busy bits, so a just-issued slot is never reused here.
      entry_d[free_idx_s] = dispatch_en_s ? new_entry_s : entry_d[free_idx_s];
   end

   // State and ALU output registers; rdy low freezes everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            entry_q[i] <= '0;
         end
         alu_op_q      <= OP_NOP;
         alu_value1_q  <= '0;
         alu_value2_q  <= '0;
         alu_imm_q     <= '0;
         alu_pc_q      <= '0;
         alu_rob_tag_q <= TAG_NONE;
      end else if (rdy) begin
         entry_q       <= entry_d;
         alu_op_q      <= alu_op_d;
         alu_value1_q  <= alu_value1_d;
         alu_value2_q  <= alu_value2_d;
         alu_imm_q     <= alu_imm_d;
         alu_pc_q      <= alu_pc_d;
         alu_rob_tag_q <= alu_rob_tag_d;
      end
   end

   assign bus.out_full    = (busy_cnt_s >= CNT_W'(RS_SIZE - 1));
   assign bus.alu_op      = alu_op_q;
   assign bus.alu_value1  = alu_value1_q;
   assign bus.alu_value2  = alu_value2_q;
   assign bus.alu_imm     = alu_imm_q;
   assign bus.alu_pc      = alu_pc_q;
   assign bus.alu_rob_tag = alu_rob_tag_q;
endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Directed bench for rs_alu_scheduler: issue latency, CDB snoop/bypass, ordering,
// full flag, overflow drop, flush and asynchronous reset.
module tb_rs_alu_scheduler;
   localparam logic [5:0] OP_NOP = 6'd0;
   localparam logic [5:0] OP_ADD = 6'd1;
   localparam logic [5:0] OP_SUB = 6'd2;

   logic clk;
   logic rst_n;
   logic rdy;
   logic clr;
   int   pass_cnt;
   int   total_cnt;

   rs_alu_scheduler_if #(.TAG_W(4), .DATA_W(32), .OP_W(6)) bus ();

   rs_alu_scheduler #(.RS_SIZE(16), .TAG_W(4), .DATA_W(32), .OP_W(6)) dut (
      .clk (clk),
      .rst (rst_n),
      .rdy (rdy),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid      = 1'b0;
      bus.in_op         = OP_NOP;
      bus.in_q1         = 4'd0;
      bus.in_q2         = 4'd0;
      bus.in_v1         = 32'd0;
      bus.in_v2         = 32'd0;
      bus.in_imm        = 32'd0;
      bus.in_pc         = 32'd0;
      bus.in_rob_tag    = 4'd0;
      bus.alu_cdb_tag   = 4'd0;
      bus.alu_cdb_value = 32'd0;
      bus.lsb_cdb_tag   = 4'd0;
      bus.lsb_cdb_value = 32'd0;
   endtask

   task automatic drive(input logic [5:0] op, input logic [3:0] q1, input logic [31:0] v1,
                        input logic [3:0] q2, input logic [31:0] v2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [3:0] tag);
      bus.in_valid   = 1'b1;
      bus.in_op      = op;
      bus.in_q1      = q1;
      bus.in_v1      = v1;
      bus.in_q2      = q2;
      bus.in_v2      = v2;
      bus.in_imm     = imm;
      bus.in_pc      = pc;
      bus.in_rob_tag = tag;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rdy   = 1'b1;
      clr   = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if (bus.alu_op !== OP_NOP) $display("FAIL reset_op: got %0h expected %0h", bus.alu_op, OP_NOP); else pass_cnt++;
      total_cnt++; if (bus.alu_value1 !== 32'd0) $display("FAIL reset_v1: got %0h expected 0", bus.alu_value1); else pass_cnt++;
      total_cnt++; if (bus.alu_rob_tag !== 4'd0) $display("FAIL reset_tag: got %0h expected 0", bus.alu_rob_tag); else pass_cnt++;
      total_cnt++; if (bus.out_full !== 1'b0) $display("FAIL reset_full: got %0b expected 0", bus.out_full); else pass_cnt++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_add();
      drive(OP_ADD, 4'd0, 32'd5, 4'd0, 32'd7, 32'h11, 32'h100, 4'd3);
      step();
      idle();
      total_cnt++; if (bus.alu_op !== OP_NOP) $display("FAIL add_early: got %0h expected %0h", bus.alu_op, OP_NOP); else pass_cnt++;
      step();
      total_cnt++; if (bus.alu_op !== OP_ADD) $display("FAIL add_op: got %0h expected %0h", bus.alu_op, OP_ADD); else pass_cnt++;
      total_cnt++; if (bus.alu_value1 !== 32'd5) $display("FAIL add_v1: got %0h expected 5", bus.alu_value1); else pass_cnt++;
      total_cnt++; if (bus.alu_value2 !== 32'd7) $display("FAIL add_v2: got %0h expected 7", bus.alu_value2); else pass_cnt++;
      total_cnt++; if (bus.alu_imm !== 32'h11) $display("FAIL add_imm: got %0h expected 11", bus.alu_imm); else pass_cnt++;
      total_cnt++; if (bus.alu_pc !== 32'h100) $display("FAIL add_pc: got %0h expected 100", bus.alu_pc); else pass_cnt++;
      total_cnt++; if (bus.alu_rob_tag !== 4'd3) $display("FAIL add_tag: got %0h expected 3", bus.alu_rob_tag); else pass_cnt++;
      step();
      total_cnt++; if (bus.alu_op !== OP_NOP) $display("FAIL add_after_op: got %0h expected %0h", bus.alu_op, OP_NOP); else pass_cnt++;
      total_cnt++; if (bus.alu_rob_tag !== 4'd0) $display("FAIL add_after_tag: got %0h expected 0", bus.alu_rob_tag); else pass_cnt++;
      total_cnt++; if (bus.alu_value1 !== 32'd5) $display("FAIL add_hold_v1: got %0h expected 5", bus.alu_value1); else pass_cnt++;
   endtask

   task automatic test_snoop();
      drive(OP_SUB, 4'd2, 32'd0, 4'd3, 32'd0, 32'd0, 32'h104, 4'd4);
      step();
      idle();
      step();
      total_cnt++; if (bus.alu_op !== OP_NOP) $display("FAIL snoop_wait: got %0h expected %0h", bus.alu_op, OP_NOP); else pass_cnt++;
      bus.alu_cdb_tag   = 4'd2;
      bus.alu_cdb_value = 32'h10;
      bus.lsb_cdb_tag   = 4'd3;
      bus.lsb_cdb_value = 32'h20;
      step();
      idle();
      total_cnt++; if (bus.alu_op !== OP_NOP) $display("FAIL snoop_edge: got %0h expected %0h", bus.alu_op, OP_NOP); else pass_cnt++;
      step();
      total_cnt++; if (bus.alu_op !== OP_SUB) $display("FAIL snoop_op: got %0h expected %0h", bus.alu_op, OP_SUB); else pass_cnt++;
      total_cnt++; if (bus.alu_value1 !== 32'h10) $display("FAIL snoop_v1: got %0h expected 10", bus.alu_value1); else pass_cnt++;
      total_cnt++; if (bus.alu_value2 !== 32'h20) $display("FAIL snoop_v2: got %0h expected 20", bus.alu_value2); else pass_cnt++;
      total_cnt++; if (bus.alu_rob_tag !== 4'd4) $display("FAIL snoop_tag: got %0h expected 4", bus.alu_rob_tag); else pass_cnt++;
   endtask

   task automatic test_bypass();
      drive(OP_ADD, 4'd0, 32'd1, 4'd6, 32'd0, 32'd0, 32'h108, 4'd5);
      bus.lsb_cdb_tag   = 4'd6;
      bus.lsb_cdb_value = 32'hAB;
      step();
      idle();
      step();
      total_cnt++; if (bus.alu_rob_tag !== 4'd5) $display("FAIL bypass_tag: got %0h expected 5", bus.alu_rob_tag); else pass_cnt++;
      total_cnt++; if (bus.alu_value1 !== 32'd1) $display("FAIL bypass_v1: got %0h expected 1", bus.alu_value1); else pass_cnt++;
      total_cnt++; if (bus.alu_value2 !== 32'hAB) $display("FAIL bypass_v2: got %0h expected ab", bus.alu_value2); else pass_cnt++;
      step();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         drive(OP_ADD, 4'd10, 32'd0, 4'd0, 32'(i), 32'h70 + 32'(i), 32'h200, 4'(7 + i));
         step();
      end
      idle();
      total_cnt++; if (bus.alu_op !== OP_NOP) $display("FAIL b2b_wait: got %0h expected %0h", bus.alu_op, OP_NOP); else pass_cnt++;
      bus.alu_cdb_tag   = 4'd10;
      bus.alu_cdb_value = 32'h55;
      step();
      idle();
      step();
      total_cnt++; if (bus.alu_rob_tag !== 4'd7) $display("FAIL b2b_tag0: got %0h expected 7", bus.alu_rob_tag); else pass_cnt++;
      total_cnt++; if (bus.alu_value1 !== 32'h55) $display("FAIL b2b_v1: got %0h expected 55", bus.alu_value1); else pass_cnt++;
      total_cnt++; if (bus.alu_imm !== 32'h70) $display("FAIL b2b_imm0: got %0h expected 70", bus.alu_imm); else pass_cnt++;
      rdy = 1'b0;
      step();
      total_cnt++; if (bus.alu_rob_tag !== 4'd7) $display("FAIL freeze_tag: got %0h expected 7", bus.alu_rob_tag); else pass_cnt++;
      rdy = 1'b1;
      step();
      total_cnt++; if (bus.alu_rob_tag !== 4'd8) $display("FAIL b2b_tag1: got %0h expected 8", bus.alu_rob_tag); else pass_cnt++;
      total_cnt++; if (bus.alu_imm !== 32'h71) $display("FAIL b2b_imm1: got %0h expected 71", bus.alu_imm); else pass_cnt++;
      step();
      total_cnt++; if (bus.alu_rob_tag !== 4'd9) $display("FAIL b2b_tag2: got %0h expected 9", bus.alu_rob_tag); else pass_cnt++;
      total_cnt++; if (bus.alu_value2 !== 32'd2) $display("FAIL b2b_v2: got %0h expected 2", bus.alu_value2); else pass_cnt++;
      step();
      total_cnt++; if (bus.alu_op !== OP_NOP) $display("FAIL b2b_drain: got %0h expected %0h", bus.alu_op, OP_NOP); else pass_cnt++;
   endtask

   task automatic test_full();
      for (int i = 0; i < 15; i++) begin
         drive(OP_ADD, 4'(i + 1), 32'd0, 4'd0, 32'd0, 32'(i), 32'h300, 4'(15 - i));
         step();
         if (i == 13) begin
            total_cnt++; if (bus.out_full !== 1'b0) $display("FAIL full_14: got %0b expected 0", bus.out_full); else pass_cnt++;
         end
      end
      idle();
      total_cnt++; if (bus.out_full !== 1'b1) $display("FAIL full_15: got %0b expected 1", bus.out_full); else pass_cnt++;
      bus.alu_cdb_tag   = 4'd1;
      bus.alu_cdb_value = 32'h99;
      step();
      idle();
      total_cnt++; if (bus.out_full !== 1'b1) $display("FAIL full_snoop: got %0b expected 1", bus.out_full); else pass_cnt++;
      step();
      total_cnt++; if (bus.out_full !== 1'b0) $display("FAIL full_release: got %0b expected 0", bus.out_full); else pass_cnt++;
      total_cnt++; if (bus.alu_rob_tag !== 4'd15) $display("FAIL full_issue_tag: got %0h expected f", bus.alu_rob_tag); else pass_cnt++;
      total_cnt++; if (bus.alu_value1 !== 32'h99) $display("FAIL full_issue_v1: got %0h expected 99", bus.alu_value1); else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
         drive(OP_ADD, 4'd15, 32'd0, 4'd0, 32'd0, 32'd0, 32'h400, 4'd2);
         step();
      end
      drive(OP_ADD, 4'd0, 32'd3, 4'd0, 32'd4, 32'd0, 32'h500, 4'd6);
      step();
      idle();
      total_cnt++; if (bus.out_full !== 1'b1) $display("FAIL overflow_full: got %0b expected 1", bus.out_full); else pass_cnt++;
      step();
      total_cnt++; if (bus.alu_op !== OP_NOP) $display("FAIL overflow_drop: got %0h expected %0h", bus.alu_op, OP_NOP); else pass_cnt++;
   endtask

   task automatic test_clear();
      drive(OP_ADD, 4'd0, 32'd3, 4'd0, 32'd4, 32'd0, 32'h600, 4'd6);
      clr = 1'b1;
      step();
      clr = 1'b0;
      idle();
      total_cnt++; if (bus.out_full !== 1'b0) $display("FAIL clr_full: got %0b expected 0", bus.out_full); else pass_cnt++;
      step();
      total_cnt++; if (bus.alu_op !== OP_NOP) $display("FAIL clr_dispatch: got %0h expected %0h", bus.alu_op, OP_NOP); else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         drive(OP_SUB, 4'(i + 1), 32'd0, 4'd0, 32'd0, 32'd0, 32'h700, 4'(i + 1));
         step();
      end
      idle();
      bus.lsb_cdb_tag   = 4'd1;
      bus.lsb_cdb_value = 32'h5;
      step();
      idle();
      clr = 1'b1;
      step();
      clr = 1'b0;
      total_cnt++; if (bus.alu_op !== OP_NOP) $display("FAIL clr_issue_op: got %0h expected %0h", bus.alu_op, OP_NOP); else pass_cnt++;
      total_cnt++; if (bus.alu_rob_tag !== 4'd0) $display("FAIL clr_issue_tag: got %0h expected 0", bus.alu_rob_tag); else pass_cnt++;
      total_cnt++; if (bus.out_full !== 1'b0) $display("FAIL clr8_full: got %0b expected 0", bus.out_full); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         bus.alu_cdb_tag = 4'(2 + 2 * i);
         bus.lsb_cdb_tag = 4'(3 + 2 * i);
         step();
         total_cnt++; if (bus.alu_op !== OP_NOP) $display("FAIL clr_ghost: got %0h expected %0h", bus.alu_op, OP_NOP); else pass_cnt++;
      end
      idle();
   endtask

   task automatic test_reset_mid();
      drive(OP_ADD, 4'd0, 32'd8, 4'd0, 32'd9, 32'd0, 32'h800, 4'd10);
      step();
      drive(OP_SUB, 4'd0, 32'd1, 4'd0, 32'd2, 32'd0, 32'h804, 4'd11);
      step();
      idle();
      total_cnt++; if (bus.alu_rob_tag !== 4'd10) $display("FAIL mid_pre_tag: got %0h expected a", bus.alu_rob_tag); else pass_cnt++;
      #3;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (bus.alu_op !== OP_NOP) $display("FAIL mid_rst_op: got %0h expected %0h", bus.alu_op, OP_NOP); else pass_cnt++;
      total_cnt++; if (bus.alu_value1 !== 32'd0) $display("FAIL mid_rst_v1: got %0h expected 0", bus.alu_value1); else pass_cnt++;
      #2;
      rst_n = 1'b1;
      step();
      total_cnt++; if (bus.alu_op !== OP_NOP) $display("FAIL mid_rst_after: got %0h expected %0h", bus.alu_op, OP_NOP); else pass_cnt++;
      total_cnt++; if (bus.alu_rob_tag !== 4'd0) $display("FAIL mid_rst_tag: got %0h expected 0", bus.alu_rob_tag); else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_add();
      test_snoop();
      test_bypass();
      test_back_to_back();
      test_full();
      test_clear();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
